// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM encodings and request-field layout for mem_access_unit.
package mem_access_pkg;

    // Access size encodings on req_mode / mem_mode
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    // Request fields latched at accept (address kept separately, its width is a parameter)
    typedef struct packed {
        logic        we;
        logic [1:0]  mode;
        logic        sgn;
        logic [31:0] wdata;
    } req_fields_t;

    // Illegal mode or an address not aligned to the access size
    function automatic logic req_is_bad(input logic [1:0] mode, input logic [1:0] addr_lo);
        logic bad;
        case (mode)
            MODE_BYTE: bad = 1'b0;
            MODE_HALF: bad = addr_lo[0];
            MODE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide data-memory port of mem_access_unit.
// slave: the unit itself. master: the pipeline stage and the memory it talks to.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 12
);
    // Pipeline request / response
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_mode;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    // Data-memory port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [1:0]            mem_mode;
    logic                  mem_str;
    logic                  mem_sel;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_mode, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_mode, mem_str, mem_sel
    );

    modport master (
        output req_valid, req_we, req_mode, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_mode, mem_str, mem_sel
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,    // word read from memory (load path)
    input  logic [31:0] old_word,   // word captured for read-modify-write
    input  logic [31:0] st_data,    // right-aligned store data
    input  logic [1:0]  byte_off,
    input  logic [1:0]  mode,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/halfword lane and extend it to 32 bits
    always_comb begin
        lane_b = 8'h00;
        unique case (byte_off)
            2'd0: lane_b = rd_word[7:0];
            2'd1: lane_b = rd_word[15:8];
            2'd2: lane_b = rd_word[23:16];
            2'd3: lane_b = rd_word[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

        case (mode)
            MODE_BYTE: load_data = {{24{is_signed & lane_b[7]}}, lane_b};
            MODE_HALF: load_data = {{16{is_signed & lane_h[15]}}, lane_h};
            default:   load_data = rd_word;
        endcase
    end

    // Replace only the addressed lane; all other bytes keep their read values
    always_comb begin
        merged = old_word;
        case (mode)
            MODE_BYTE: begin
                unique case (byte_off)
                    2'd0: merged[7:0]   = st_data[7:0];
                    2'd1: merged[15:8]  = st_data[7:0];
                    2'd2: merged[23:16] = st_data[7:0];
                    2'd3: merged[31:24] = st_data[7:0];
                    default: merged = old_word;
                endcase
            end
            MODE_HALF: begin
                if (byte_off[1]) begin
                    merged[31:16] = st_data[15:0];
                end else begin
                    merged[15:0] = st_data[15:0];
                end
            end
            default: merged = st_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: one outstanding load/store at a time,
// word-mode memory cycles only, sub-word stores done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input logic                clk,
    input logic                clr,
    mem_access_unit_if.slave   bus
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    req_fields_t           fld_q;
    logic [31:0]           rword_q;
    logic [31:0]           resp_rdata_q;
    logic                  resp_err_q;

    logic                  accept;
    logic                  bad_req;
    logic [31:0]           load_data;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign accept    = bus.req_valid && (state_q == ST_IDLE);
    assign bad_req   = req_is_bad(bus.req_mode, bus.req_addr[1:0]);
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    mem_load_align u_align (
        .rd_word   (bus.mem_rdata),
        .old_word  (rword_q),
        .st_data   (fld_q.wdata),
        .byte_off  (addr_q[1:0]),
        .mode      (fld_q.mode),
        .is_signed (fld_q.sgn),
        .load_data (load_data),
        .merged    (merged)
    );

    // Next-state: errors skip the memory; word stores skip the read
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_req) begin
                        state_d = ST_RESP;
                    end else if (bus.req_we && (bus.req_mode == MODE_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = fld_q.we ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register; clr aborts any in-flight access immediately
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch request fields at accept, and the old word during the RMW read
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            addr_q  <= '0;
            fld_q   <= '0;
            rword_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                fld_q  <= '{we: bus.req_we, mode: bus.req_mode, sgn: bus.req_signed,
                           wdata: bus.req_wdata};
            end
            if ((state_q == ST_READ) && fld_q.we) begin
                rword_q <= bus.mem_rdata;
            end
        end
    end

    // Response data/error, updated only on the transition into RESP and held after
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept && bad_req) begin
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b1;
            end else if ((state_q == ST_READ) && !fld_q.we) begin
                resp_rdata_q <= load_data;
                resp_err_q   <= 1'b0;
            end else if (state_q == ST_WRITE) begin
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b0;
            end
        end
    end

    // Memory port is a pure decode of state and latched fields
    always_comb begin
        bus.mem_sel   = 1'b0;
        bus.mem_str   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            ST_READ: begin
                bus.mem_sel  = 1'b1;
                bus.mem_addr = word_addr;
            end
            ST_WRITE: begin
                bus.mem_sel   = 1'b1;
                bus.mem_str   = 1'b1;
                bus.mem_addr  = word_addr;
                bus.mem_wdata = (fld_q.mode == MODE_WORD) ? fld_q.wdata : merged;
            end
            default: begin
                bus.mem_sel = 1'b0;
            end
        endcase
    end

    assign bus.mem_mode   = MODE_WORD;
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized
// sequence checked against a behavioural model of loads, stores and a word memory.
module tb_mem_access_unit;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Word memory attached to the port, plus a preload path for the bench
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_val;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (bus.mem_sel && bus.mem_str) mem[bus.mem_addr[AW-1:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[AW-1:2]];

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic logic m_err(input logic [1:0] mode, input logic [AW-1:0] addr);
        return (mode == 2'd3) || (mode == 2'd1 && (addr % 2) != 0) ||
               (mode == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic int m_lat(input logic we, input logic [1:0] mode, input logic err);
        if (err) return 1;
        if (!we || mode == 2'd2) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] mode,
                                           input logic sgn, input logic [AW-1:0] addr);
        logic [31:0] v;
        int sh;
        if (mode == 2'd2) return w;
        if (mode == 2'd0) begin
            sh = 8 * int'(addr % 4);
            v  = (w >> sh) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else begin
            sh = 16 * int'((addr / 2) % 2);
            v  = (w >> sh) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [1:0] mode,
                                            input logic [AW-1:0] addr, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (mode == 2'd2) return d;
        if (mode == 2'd0) begin
            sh   = 8 * int'(addr % 4);
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * int'((addr / 2) % 2);
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    // ---------------- drivers ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 10'(idx);
        pl_val = val;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one request and observe it until resp_valid (bounded); lat=0 means no response
    task automatic run_req(input logic we, input logic [1:0] mode, input logic sgn,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int n_sel, output int n_str,
                           output logic [AW-1:0] st_addr, output logic [31:0] st_data);
        lat = 0; n_sel = 0; n_str = 0; rdata = 'x; err = 1'bx; st_addr = '0; st_data = '0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_mode   = mode;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.mem_sel) n_sel++;
            if (bus.mem_str) begin
                n_str++;
                st_addr = bus.mem_addr;
                st_data = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                lat   = k;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b1;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_mode = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #2;
        for (int pass = 0; pass < 2; pass++) begin
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", bus.req_ready); end
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b expected 0", bus.resp_valid); end
            checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset resp_rdata: got %h expected 0", bus.resp_rdata); end
            checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err: got %b expected 0", bus.resp_err); end
            checks++; if (bus.mem_addr !== 12'h0) begin errors++; $display("FAIL reset mem_addr: got %h expected 0", bus.mem_addr); end
            checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata: got %h expected 0", bus.mem_wdata); end
            checks++; if (bus.mem_str !== 1'b0 || bus.mem_sel !== 1'b0) begin errors++; $display("FAIL reset mem_str/sel: got %b%b expected 00", bus.mem_str, bus.mem_sel); end
            checks++; if (bus.mem_mode !== 2'b10) begin errors++; $display("FAIL reset mem_mode: got %b expected 10", bus.mem_mode); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_word_store();
        int lat, ns, nw; logic [31:0] rd, sd; logic er; logic [AW-1:0] sa;
        preload(4, 32'h0);
        run_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd, er, ns, nw, sa, sd);
        ref_mem[4] = 32'hDEADBEEF;
        checks++; if (lat != 2) begin errors++; $display("FAIL wstore latency: got %0d expected 2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wstore err: got %b expected 0", er); end
        checks++; if (nw != 1 || ns != 1) begin errors++; $display("FAIL wstore str/sel cycles: got %0d/%0d expected 1/1", nw, ns); end
        checks++; if (sa !== 12'h010) begin errors++; $display("FAIL wstore mem_addr: got %h expected 010", sa); end
        checks++; if (sd !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore mem_wdata: got %h expected deadbeef", sd); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore memory: got %h expected deadbeef", mem[4]); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wstore rdata: got %h expected 0", rd); end
    endtask

    task automatic test_byte_store();
        int lat, ns, nw; logic [31:0] rd, sd; logic er; logic [AW-1:0] sa;
        run_req(1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AA, lat, rd, er, ns, nw, sa, sd);
        ref_mem[4] = 32'hDEADAAEF;
        checks++; if (lat != 3) begin errors++; $display("FAIL bstore latency: got %0d expected 3", lat); end
        checks++; if (ns != 2 || nw != 1) begin errors++; $display("FAIL bstore sel/str cycles: got %0d/%0d expected 2/1", ns, nw); end
        checks++; if (sd !== 32'hDEADAAEF || sa !== 12'h010) begin errors++; $display("FAIL bstore write: got %h@%h expected deadaaef@010", sd, sa); end
        checks++; if (mem[4] !== 32'hDEADAAEF) begin errors++; $display("FAIL bstore memory: got %h expected deadaaef", mem[4]); end
    endtask

    task automatic test_loads();
        logic [AW-1:0] a_t [5] = '{12'h013, 12'h013, 12'h012, 12'h010, 12'h010};
        logic [1:0]    m_t [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic          s_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0]   e_t [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000AAEF,
                                   32'hDEADAAEF};
        int lat, ns, nw; logic [31:0] rd, sd; logic er; logic [AW-1:0] sa;
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, m_t[i], s_t[i], a_t[i], 32'h12345678, lat, rd, er, ns, nw, sa, sd);
            checks++; if (rd !== e_t[i]) begin errors++; $display("FAIL load%0d rdata: got %h expected %h", i, rd, e_t[i]); end
            checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL load%0d lat/err: got %0d/%b expected 2/0", i, lat, er); end
            checks++; if (nw != 0 || ns != 1) begin errors++; $display("FAIL load%0d str/sel cycles: got %0d/%0d expected 0/1", i, nw, ns); end
        end
    endtask

    task automatic test_errors();
        logic          w_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]    m_t [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [AW-1:0] a_t [4] = '{12'h012, 12'h011, 12'h010, 12'h011};
        int lat, ns, nw; logic [31:0] rd, sd; logic er; logic [AW-1:0] sa;
        for (int i = 0; i < 4; i++) begin
            run_req(w_t[i], m_t[i], 1'b1, a_t[i], 32'hCAFEF00D, lat, rd, er, ns, nw, sa, sd);
            checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL err%0d err/lat: got %b/%0d expected 1/1", i, er, lat); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d rdata: got %h expected 0", i, rd); end
            checks++; if (ns != 0 || nw != 0) begin errors++; $display("FAIL err%0d sel/str cycles: got %0d/%0d expected 0/0", i, ns, nw); end
        end
        checks++; if (mem[4] !== 32'hDEADAAEF) begin errors++; $display("FAIL err memory: got %h expected deadaaef", mem[4]); end
    endtask

    task automatic test_clr_abort();
        int seen_resp = 0;
        preload(4, 32'hDEADBEEF);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_mode = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 12'h011; bus.req_wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.mem_str !== 1'b1) begin errors++; $display("FAIL abort in-write mem_str: got %b expected 1", bus.mem_str); end
        #1;
        clr = 1'b1;
        #1;
        checks++; if (bus.mem_str !== 1'b0 || bus.mem_sel !== 1'b0) begin errors++; $display("FAIL abort async drop str/sel: got %b%b expected 00", bus.mem_str, bus.mem_sel); end
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid === 1'b1) seen_resp++;
        end
        checks++; if (seen_resp != 0) begin errors++; $display("FAIL abort resp_valid: got %0d pulses expected 0", seen_resp); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL abort memory: got %h expected deadbeef", mem[4]); end
    endtask

    task automatic test_random();
        int lat, ns, nw, elat; logic [31:0] rd, sd, exp_rd; logic er, eerr; logic [AW-1:0] sa;
        logic we, sgn; logic [1:0] mode; logic [AW-1:0] addr; logic [31:0] wd; int idx;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            addr = AW'($urandom_range(0, 63));
            wd   = $urandom;
            idx  = int'(addr / 4);
            eerr = m_err(mode, addr);
            elat = m_lat(we, mode, eerr);
            exp_rd = (eerr || we) ? 32'h0 : m_load(ref_mem[idx], mode, sgn, addr);
            if (!eerr && we) ref_mem[idx] = m_merge(ref_mem[idx], mode, addr, wd);
            run_req(we, mode, sgn, addr, wd, lat, rd, er, ns, nw, sa, sd);
            checks++; if (er !== eerr || lat != elat) begin errors++; $display("FAIL rand%0d err/lat: got %b/%0d expected %b/%0d", n, er, lat, eerr, elat); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d rdata: got %h expected %h", n, rd, exp_rd); end
            checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rand%0d memory word %0d: got %h expected %h", n, idx, mem[idx], ref_mem[idx]); end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_loads();
        test_errors();
        test_clr_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory interface: accepts load/store requests from the CPU pipeline and drives the word-wide memory port (Addr, Data_input, Mode, str, sel, Data_output). The memory port is used in word mode only. Sub-word stores are done as read-modify-write. Sub-word loads are lane-extracted and sign- or zero-extended here. Sits between the MEM pipeline stage and the data memory; one request is outstanding at a time.

Parameters:
ADDR_WIDTH, 12, byte-address width shared with the memory; word index is addr[ADDR_WIDTH-1:2]

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept a request
req_we  in  1  1 = store, 0 = load
req_mode  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  load sign-extends when 1
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  aligned, extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal request, valid with resp_valid
mem_addr  out  ADDR_WIDTH  memory Addr
mem_wdata  out  32  memory Data_input
mem_mode  out  2  constant 2'b10 (word)
mem_str  out  1  memory write enable
mem_sel  out  1  memory select
mem_rdata  in  32  memory Data_output, combinational read of mem_addr

Behaviour:
- Clock and reset: single clock clk; clr is asynchronous and active-high.
- States: IDLE, READ, WRITE, RESP.
- Reset values: state IDLE. All request-capture registers are 0. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_str=0, mem_sel=0, mem_mode=2'b10.
- Accept: a request is accepted when req_valid and req_ready are both 1. req_ready=1 only in IDLE. On accept, latch addr, wdata, mode, we and signed.
- Error check at accept: mode 11, halfword with addr[0]=1, or word with addr[1:0]!=0 goes to RESP with resp_err=1. No memory cycle is issued (mem_sel and mem_str stay 0).
- Load: IDLE -> READ -> RESP.
  - In READ: mem_sel=1 and mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}; the extracted and extended result is registered.
- Word store: IDLE -> WRITE -> RESP.
- Byte or halfword store: IDLE -> READ -> WRITE -> RESP.
  - In READ: mem_rdata is captured.
  - In WRITE: the merged word is driven.
- WRITE: mem_sel=1 and mem_str=1 for exactly one cycle. mem_wdata is the full word (store data) or the merged word (sub-word store).
- Memory-side outputs are combinational from the state and the latched fields. Outside READ and WRITE, mem_sel=0 and mem_str=0.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response backpressure.
- Latency from the accept edge to resp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Load lanes:
  - byte: lane k = addr[1:0] selects bits [8k+7:8k]
  - halfword: addr[1] selects [31:16] or [15:0]
  - extension: sign-extend when signed=1, otherwise zero-extend; word loads pass through unchanged
- Store merge: the byte lane is replaced by wdata[7:0], or the halfword lane by wdata[15:0]. Other bytes keep their read values.
- resp_rdata holds its value until the next RESP.
- clr mid-operation: the FSM goes to IDLE immediately and mem_str/mem_sel drop asynchronously. No write is committed and no resp_valid is issued for the aborted request.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package mem_access_pkg:
  - MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b10
  - state encodings IDLE/READ/WRITE/RESP
- Sub-module mem_load_align: combinational lane extract plus sign/zero extend, and the store-merge function. The FSM and registers stay in mem_access_unit.

Test Plan:
- Word store, addr 0x010, data 0xDEADBEEF -> mem_str high for exactly 1 cycle with mem_addr=0x010 and mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept; resp_err=0.
- Byte store, addr 0x011, data 0x000000AA, over memory word 0xDEADBEEF -> READ then WRITE with mem_wdata=0xDEADAAEF; resp_valid 3 cycles after accept.
- Byte load, addr 0x013, word 0xDEADAAEF -> signed gives resp_rdata=0xFFFFFFDE; unsigned gives 0x000000DE; 2-cycle latency.
- Halfword loads from 0xDEADAAEF -> addr 0x012 signed gives 0xFFFFDEAD; addr 0x010 unsigned gives 0x0000AAEF.
- Misaligned and illegal requests -> word load at 0x012, halfword at 0x011, and mode 11 each give resp_err=1 and resp_rdata=0 one cycle after accept; mem_sel never asserted.
- clr pulsed while in WRITE of a byte store -> mem_str falls immediately; memory word still 0xDEADBEEF; no resp_valid; req_ready=1 after clr releases.
